// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: arbitrates button packets, coalesced mouse motion and
// keepalive polls onto one SPI master, then routes each response back.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   btn_data/btn_valid/btn_ready    priority packet into a 1-entry holder
//   mv_dx/mv_dy/mv_valid            signed motion deltas, always accepted
//   spi_tx_data/_valid/_ready       packet handshake to the SPI master
//   spi_rx_data/_valid              transaction-complete pulse and data
//   resp_data/_valid/_src           routed response (src 0 btn,1 move,2 poll)
//   busy                            transaction in flight
module spi_cmd_scheduler #(
   parameter int unsigned KEEPALIVE_CYCLES = 48000,
   parameter logic [7:0]  MOVE_OP          = 8'h01,
   parameter logic [7:0]  POLL_OP          = 8'hF0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] btn_data,
   input  logic        btn_valid,
   output logic        btn_ready,
   input  logic [15:0] mv_dx,
   input  logic [15:0] mv_dy,
   input  logic        mv_valid,
   output logic [63:0] spi_tx_data,
   output logic        spi_tx_valid,
   input  logic        spi_tx_ready,
   input  logic [63:0] spi_rx_data,
   input  logic        spi_rx_valid,
   output logic [63:0] resp_data,
   output logic        resp_valid,
   output logic [1:0]  resp_src,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_t;

   localparam int KW =
      (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
   localparam logic [KW-1:0] KA_LAST = KW'(KEEPALIVE_CYCLES - 1);

   localparam logic [1:0] SRC_BTN  = 2'd0;
   localparam logic [1:0] SRC_MOVE = 2'd1;
   localparam logic [1:0] SRC_POLL = 2'd2;

   state_t        state_q, state_d;
   logic          btn_full_q, btn_full_d;
   logic [63:0]   btn_q, btn_d;
   logic [15:0]   acc_x_q, acc_x_d;
   logic [15:0]   acc_y_q, acc_y_d;
   logic [KW-1:0] ka_q, ka_d;
   logic          poll_q, poll_d;
   logic [63:0]   tx_q, tx_d;
   logic [1:0]    src_q, src_d;
   logic [63:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;
   logic [1:0]    rsrc_q, rsrc_d;

   logic          ka_hit;
   logic          mv_pend;
   logic          move_sel;
   logic [15:0]   base_x, base_y;

   // Sign-extend to 17 bits; a top-two-bit disagreement means overflow.
   function automatic logic [15:0] sat_add(input logic [15:0] a,
                                           input logic [15:0] b);
      logic [16:0] s;
      s = {a[15], a} + {b[15], b};
      if (s[16] != s[15]) sat_add = s[16] ? 16'h8000 : 16'h7FFF;
      else                sat_add = s[15:0];
   endfunction

   assign ka_hit  = (ka_q == KA_LAST);
   assign mv_pend = (acc_x_q != 16'h0) || (acc_y_q != 16'h0);

   always_comb begin
      state_d    = state_q;
      btn_full_d = btn_full_q;
      btn_d      = btn_q;
      ka_d       = ka_hit ? '0 : ka_q + KW'(1);
      poll_d     = poll_q;
      tx_d       = tx_q;
      src_d      = src_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      rsrc_d     = rsrc_q;
      move_sel   = 1'b0;

      if (btn_valid && !btn_full_q) begin
         btn_full_d = 1'b1;
         btn_d      = btn_data;
      end

      case (state_q)
         IDLE: begin
            if (btn_full_q) begin
               tx_d       = btn_q;
               src_d      = SRC_BTN;
               btn_full_d = 1'b0;
               state_d    = LAUNCH;
            end else if (mv_pend) begin
               tx_d     = {MOVE_OP, 8'h00, acc_x_q, acc_y_q, 16'h0000};
               src_d    = SRC_MOVE;
               move_sel = 1'b1;
               state_d  = LAUNCH;
            end else if (poll_q) begin
               tx_d    = {POLL_OP, 56'h0};
               src_d   = SRC_POLL;
               poll_d  = 1'b0;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            if (spi_tx_ready) begin
               ka_d    = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (spi_rx_valid) begin
               rdata_d  = spi_rx_data;
               rsrc_d   = src_q;
               rvalid_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Snapshot clears the accumulators; a same-cycle delta starts afresh.
      base_x  = move_sel ? 16'h0 : acc_x_q;
      base_y  = move_sel ? 16'h0 : acc_y_q;
      acc_x_d = mv_valid ? sat_add(base_x, mv_dx) : base_x;
      acc_y_d = mv_valid ? sat_add(base_y, mv_dy) : base_y;

      // A keepalive expiry wins over a same-cycle poll launch.
      if (ka_hit) poll_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         btn_full_q <= 1'b0;
         btn_q      <= '0;
         acc_x_q    <= '0;
         acc_y_q    <= '0;
         ka_q       <= '0;
         poll_q     <= 1'b0;
         tx_q       <= '0;
         src_q      <= SRC_BTN;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         rsrc_q     <= SRC_BTN;
      end else begin
         state_q    <= state_d;
         btn_full_q <= btn_full_d;
         btn_q      <= btn_d;
         acc_x_q    <= acc_x_d;
         acc_y_q    <= acc_y_d;
         ka_q       <= ka_d;
         poll_q     <= poll_d;
         tx_q       <= tx_d;
         src_q      <= src_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         rsrc_q     <= rsrc_d;
      end
   end

   assign btn_ready    = !btn_full_q;
   assign spi_tx_valid = (state_q == LAUNCH);
   assign spi_tx_data  = tx_q;
   assign resp_data    = rdata_q;
   assign resp_valid   = rvalid_q;
   assign resp_src     = rsrc_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// tb_spi_cmd_scheduler: directed table, corner sequences and random traffic
// for spi_cmd_scheduler, checked against a transaction-level reference.
module tb_spi_cmd_scheduler;

   localparam int KA = 64;

   logic        clk;
   logic        rst_n;
   logic [63:0] btn_data;
   logic        btn_valid;
   logic        btn_ready;
   logic [15:0] mv_dx;
   logic [15:0] mv_dy;
   logic        mv_valid;
   logic [63:0] spi_tx_data;
   logic        spi_tx_valid;
   logic        spi_tx_ready;
   logic [63:0] spi_rx_data;
   logic        spi_rx_valid;
   logic [63:0] resp_data;
   logic        resp_valid;
   logic [1:0]  resp_src;
   logic        busy;

   spi_cmd_scheduler #(
      .KEEPALIVE_CYCLES(KA),
      .MOVE_OP(8'h01),
      .POLL_OP(8'hF0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_data(btn_data),
      .btn_valid(btn_valid),
      .btn_ready(btn_ready),
      .mv_dx(mv_dx),
      .mv_dy(mv_dy),
      .mv_valid(mv_valid),
      .spi_tx_data(spi_tx_data),
      .spi_tx_valid(spi_tx_valid),
      .spi_tx_ready(spi_tx_ready),
      .spi_rx_data(spi_rx_data),
      .spi_rx_valid(spi_rx_valid),
      .resp_data(resp_data),
      .resp_valid(resp_valid),
      .resp_src(resp_src),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   // Reference: pending work (held button, summed motion, poll flag)
   // and where the single transaction slot is (0 free, 1 offered, 2 wait).
   int          m_ph;
   bit          m_bf;
   logic [63:0] m_b;
   int          m_ax, m_ay;
   int          m_idle_cnt;
   bit          m_poll;
   logic [63:0] m_tx;
   int          m_src;
   bit          m_rv;
   logic [63:0] m_rd;
   int          m_rsrc;

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_bf = 0; m_b = '0; m_ax = 0; m_ay = 0;
      m_idle_cnt = 0; m_poll = 0; m_tx = '0; m_src = 0;
      m_rv = 0; m_rd = '0; m_rsrc = 0;
   endtask

   task automatic model_step();
      int ph_n, ax_n, ay_n, cnt_n;
      bit bf_n, poll_n, expired;
      logic [63:0] b_n;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ph_n = m_ph; ax_n = m_ax; ay_n = m_ay;
      bf_n = m_bf; b_n = m_b; poll_n = m_poll;
      expired = (m_idle_cnt == KA - 1);
      cnt_n = expired ? 0 : m_idle_cnt + 1;
      m_rv = 0;
      if (btn_valid && !m_bf) begin
         bf_n = 1; b_n = btn_data;
      end
      if (m_ph == 0) begin
         if (m_bf) begin
            m_tx = m_b; m_src = 0; bf_n = 0; ph_n = 1;
         end else if (m_ax != 0 || m_ay != 0) begin
            m_tx = {8'h01, 8'h00, 16'(m_ax), 16'(m_ay), 16'h0};
            m_src = 1; ax_n = 0; ay_n = 0; ph_n = 1;
         end else if (m_poll) begin
            m_tx = {8'hF0, 56'h0}; m_src = 2; poll_n = 0; ph_n = 1;
         end
      end else if (m_ph == 1) begin
         if (spi_tx_ready) begin
            ph_n = 2; cnt_n = 0;
         end
      end else if (spi_rx_valid) begin
         m_rv = 1; m_rd = spi_rx_data; m_rsrc = m_src; ph_n = 0;
      end
      if (mv_valid) begin
         ax_n = clamp16(ax_n + int'($signed(mv_dx)));
         ay_n = clamp16(ay_n + int'($signed(mv_dy)));
      end
      if (expired) poll_n = 1;
      m_ph = ph_n; m_ax = ax_n; m_ay = ay_n; m_bf = bf_n;
      m_b = b_n; m_poll = poll_n; m_idle_cnt = cnt_n;
   endtask

   task automatic check_all();
      chk("tx_valid", 64'(spi_tx_valid), 64'(m_ph == 1));
      chk("tx_data", spi_tx_data, m_tx);
      chk("busy", 64'(busy), 64'(m_ph != 0));
      chk("btn_ready", 64'(btn_ready), 64'(!m_bf));
      chk("resp_valid", 64'(resp_valid), 64'(m_rv));
      chk("resp_data", resp_data, m_rd);
      chk("resp_src", 64'(resp_src), 64'(m_rsrc));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_in();
      btn_valid = 0; btn_data = '0; mv_valid = 0; mv_dx = '0; mv_dy = '0;
      spi_tx_ready = 0; spi_rx_valid = 0; spi_rx_data = '0;
   endtask

   typedef struct {
      logic bv; logic [63:0] bd;
      logic mv; logic [15:0] dx; logic [15:0] dy;
      logic rdy; logic rxv; logic [63:0] rxd;
      logic e_txv; logic [63:0] e_txd; logic e_busy; logic e_brdy;
      logic e_rv; logic [1:0] e_rsrc; logic [63:0] e_rd;
   } vec_t;

   function automatic vec_t mk(
      input logic bv, input logic [63:0] bd, input logic mv,
      input logic [15:0] dx, input logic [15:0] dy, input logic rdy,
      input logic rxv, input logic [63:0] rxd, input logic e_txv,
      input logic [63:0] e_txd, input logic e_busy, input logic e_brdy,
      input logic e_rv, input logic [1:0] e_rsrc, input logic [63:0] e_rd);
      vec_t v;
      v.bv = bv; v.bd = bd; v.mv = mv; v.dx = dx; v.dy = dy;
      v.rdy = rdy; v.rxv = rxv; v.rxd = rxd; v.e_txv = e_txv;
      v.e_txd = e_txd; v.e_busy = e_busy; v.e_brdy = e_brdy;
      v.e_rv = e_rv; v.e_rsrc = e_rsrc; v.e_rd = e_rd;
      return v;
   endfunction

   localparam logic [63:0] B  = 64'h0203_0000_0000_0000;
   localparam logic [63:0] B2 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] M1 = 64'h0100_0032_FFF1_0000;
   localparam logic [63:0] M2 = 64'h0100_0005_0000_0000;
   localparam logic [63:0] R1 = 64'hAAAA_0000_0000_5555;
   localparam logic [15:0] D3 = 16'hFFFD;

   vec_t tbl[21];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      tbl[0]  = mk(1, B, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, B, 1, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 10, D3, 1, 0, 0, 0, B, 1, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 10, D3, 0, 0, 0, 0, B, 1, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 1, 10, D3, 0, 0, 0, 0, B, 1, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 10, D3, 0, 0, 0, 0, B, 1, 1, 0, 0, 0);
      tbl[6]  = mk(0, 0, 1, 10, D3, 0, 0, 0, 0, B, 1, 1, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, R1, 0, B, 0, 1, 1, 0, R1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, M1, 1, 1, 0, 0, R1);
      tbl[9]  = mk(1, B2, 0, 0, 0, 0, 1, 64'hDEAD, 1, M1, 1, 0, 0, 0, R1);
      tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, M1, 1, 0, 0, 0, R1);
      tbl[11] = mk(0, 0, 1, 5, 0, 0, 0, 0, 0, M1, 1, 0, 0, 0, R1);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, M1, 0, 0, 1, 1, 1);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, B2, 1, 1, 0, 1, 1);
      tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, B2, 1, 1, 0, 1, 1);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 2, 0, B2, 0, 1, 1, 0, 2);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, M2, 1, 1, 0, 0, 2);
      tbl[17] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, M2, 1, 1, 0, 0, 2);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, M2, 0, 1, 1, 1, 3);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, M2, 0, 1, 0, 1, 3);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 64'h99, 0, M2, 0, 1, 0, 1, 3);

      rst_n = 0;
      idle_in();
      model_reset();
      step();
      step();
      chk("rst_tx_valid", 64'(spi_tx_valid), 64'd0);
      chk("rst_btn_ready", 64'(btn_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_tx_data", spi_tx_data, 64'd0);
      rst_n = 1;

      for (int i = 0; i < 21; i++) begin
         btn_valid = tbl[i].bv; btn_data = tbl[i].bd;
         mv_valid = tbl[i].mv; mv_dx = tbl[i].dx; mv_dy = tbl[i].dy;
         spi_tx_ready = tbl[i].rdy; spi_rx_valid = tbl[i].rxv;
         spi_rx_data = tbl[i].rxd;
         step();
         chk($sformatf("t%0d_txv", i), 64'(spi_tx_valid), 64'(tbl[i].e_txv));
         chk($sformatf("t%0d_txd", i), spi_tx_data, tbl[i].e_txd);
         chk($sformatf("t%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
         chk($sformatf("t%0d_brdy", i), 64'(btn_ready), 64'(tbl[i].e_brdy));
         chk($sformatf("t%0d_rv", i), 64'(resp_valid), 64'(tbl[i].e_rv));
         chk($sformatf("t%0d_rsrc", i), 64'(resp_src), 64'(tbl[i].e_rsrc));
         chk($sformatf("t%0d_rd", i), resp_data, tbl[i].e_rd);
      end
      idle_in();

      // Saturation: hold the slot busy while two large deltas land.
      btn_valid = 1; btn_data = B; step();
      btn_valid = 0; step();
      chk("sat_launch", 64'(spi_tx_valid), 64'd1);
      mv_valid = 1; mv_dx = 16'd30000; mv_dy = 16'h8AD0; step();
      step();
      mv_valid = 0; spi_tx_ready = 1; step();
      spi_tx_ready = 0; spi_rx_valid = 1; step();
      spi_rx_valid = 0; step();
      chk("sat_pkt", spi_tx_data, 64'h0100_7FFF_8000_0000);
      chk("sat_x", 64'(spi_tx_data[47:32]), 64'h7FFF);
      spi_tx_ready = 1; step();
      spi_tx_ready = 0; spi_rx_valid = 1; step();
      chk("sat_src", 64'(resp_src), 64'd1);
      spi_rx_valid = 0;

      // Keepalive: silence until a poll is offered.
      seen = 0;
      for (int c = 0; c < KA + 8 && !seen; c++) begin
         step();
         seen = spi_tx_valid;
      end
      chk("poll_seen", 64'(seen), 64'd1);
      chk("poll_pkt", spi_tx_data, {8'hF0, 56'h0});
      spi_tx_ready = 1; step();
      spi_tx_ready = 0; spi_rx_valid = 1; spi_rx_data = 64'h5A; step();
      chk("poll_rv", 64'(resp_valid), 64'd1);
      chk("poll_src", 64'(resp_src), 64'd2);
      idle_in();

      // Reset while waiting, with a held button and motion outstanding.
      btn_valid = 1; btn_data = B2; step();
      btn_valid = 0; spi_tx_ready = 1; step();
      step();
      spi_tx_ready = 0; mv_valid = 1; mv_dx = 16'd7; step();
      mv_valid = 0; btn_valid = 1; btn_data = B; step();
      chk("pre_rst_busy", 64'(busy), 64'd1);
      btn_valid = 0;
      rst_n = 0;
      #1;
      chk("arst_txv", 64'(spi_tx_valid), 64'd0);
      chk("arst_txd", spi_tx_data, 64'd0);
      chk("arst_rv", 64'(resp_valid), 64'd0);
      chk("arst_rd", resp_data, 64'd0);
      chk("arst_rsrc", 64'(resp_src), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_brdy", 64'(btn_ready), 64'd1);
      model_reset();
      step();
      @(negedge clk);
      rst_n = 1;
      spi_rx_valid = 1; spi_rx_data = 64'h77; step();
      chk("stray_rv", 64'(resp_valid), 64'd0);
      spi_rx_valid = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("post_rst_idle", 64'(busy), 64'd0);
      end

      for (int c = 0; c < 3000; c++) begin
         btn_valid = ($urandom_range(0, 3) == 0);
         btn_data = {$urandom, $urandom};
         mv_valid = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 4) == 0) begin
            mv_dx = 16'($urandom);
            mv_dy = 16'($urandom);
         end else begin
            mv_dx = 16'(int'($urandom_range(0, 40)) - 20);
            mv_dy = 16'(int'($urandom_range(0, 40)) - 20);
         end
         spi_tx_ready = ($urandom_range(0, 1) == 0);
         spi_rx_valid = ($urandom_range(0, 3) == 0);
         spi_rx_data = {$urandom, $urandom};
         if (c > 1500 && c < 1700) begin
            btn_valid = 0;
            mv_valid = 0;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 SHALL have parameter KEEPALIVE_CYCLES, default 48000, meaning idle cycles before a poll packet is issued (1 ms at 48 MHz).
REQ-002 SHALL have parameter MOVE_OP, default 8'h01, meaning the opcode byte of coalesced mouse-move packets.
REQ-003 SHALL have parameter POLL_OP, default 8'hF0, meaning the opcode byte of keepalive/status poll packets.
REQ-004 SHALL have ports:
 clk  in  1  48 MHz system clock
 rst_n  in  1  reset, asynchronous, active-low
 btn_data  in  64  priority command packet (button/keyboard)
 btn_valid  in  1  btn_data offered
 btn_ready  out  1  one-entry button holding register empty
 mv_dx, mv_dy  in  16 each  signed relative motion deltas
 mv_valid  in  1  deltas valid this cycle (always accepted)
 spi_tx_data  out  64  packet to SPI master
 spi_tx_valid  out  1  packet offered to SPI master
 spi_tx_ready  in  1  SPI master idle
 spi_rx_data  in  64  response from SPI master
 spi_rx_valid  in  1  one-cycle transaction-complete pulse
 resp_data  out  64  routed response
 resp_valid  out  1  one-cycle response pulse
 resp_src  out  2  source of resp: 0 btn, 1 move, 2 poll
 busy  out  1  transaction in flight (state not IDLE)

Function
REQ-005 SHALL use a 3-state FSM: IDLE, LAUNCH, WAIT.
REQ-006 Button holding register SHALL load on btn_valid && btn_ready; btn_ready SHALL equal !btn_full (registered flag), deasserting the cycle after load.
REQ-007 Motion accumulators acc_x/acc_y (16-bit signed) SHALL add mv_dx/mv_dy on mv_valid, saturating to [-32768, +32767] per axis.
REQ-008 Move pending SHALL be (acc_x != 0 || acc_y != 0).
REQ-009 Keepalive counter SHALL increment every cycle, clear on every LAUNCH handshake, and set poll_pend when it reaches KEEPALIVE_CYCLES-1; poll_pend clears when a poll packet launches.
REQ-010 In IDLE, the arbiter SHALL select in fixed priority btn_full > move pending > poll_pend, latch spi_tx_data and the source, and enter LAUNCH on the next cycle; with nothing pending it stays IDLE.
REQ-011 Move packet SHALL be {MOVE_OP, 8'h00, acc_x, acc_y, 16'h0000}; poll packet SHALL be {POLL_OP, 56'h0}; btn packet SHALL be the held btn_data unchanged.
REQ-012 On move selection, accumulators SHALL be snapshotted into the packet and cleared in the same cycle; an mv_valid in that cycle SHALL become the new accumulator value (no delta lost).
REQ-013 On btn selection, btn_full SHALL clear in the same cycle (btn_ready high next cycle).
REQ-014 In LAUNCH, spi_tx_valid SHALL be 1 with spi_tx_data stable; the handshake occurs on the first cycle with spi_tx_ready=1, after which spi_tx_valid SHALL drop and the FSM enters WAIT.
REQ-015 spi_tx_valid SHALL never be 1 outside LAUNCH.
REQ-016 In WAIT, on spi_rx_valid, resp_data<=spi_rx_data, resp_src<=latched source, resp_valid pulses for exactly one cycle, and the FSM returns to IDLE.
REQ-017 spi_rx_valid outside WAIT SHALL be ignored.
REQ-018 Minimum gap between launches SHALL be 2 cycles after resp_valid (IDLE select, LAUNCH).
REQ-019 Illegal FSM encodings SHALL return to IDLE with spi_tx_valid=0.

Reset
REQ-020 On rst_n low: state IDLE, spi_tx_valid 0, spi_tx_data 0, resp_valid 0, resp_data 0, resp_src 0, busy 0, btn_ready 1 (btn_full 0), acc_x/acc_y 0, keepalive counter 0, poll_pend 0.
REQ-021 Reset mid-transaction SHALL discard held button, accumulators and the in-flight source; no resp_valid SHALL follow reset.

Verification
REQ-022 btn 64'h0203_0000_0000_0000 offered with tx_ready=1 -> spi_tx_valid 2 cycles later with that data; resp_src=0 after spi_rx_valid.
REQ-023 Five mv_valid (dx=+10, dy=-3) while busy -> one move packet {01,00,0032,FFF1,0000}; accumulators 0 afterwards.
REQ-024 Accumulate dx=+30000 twice -> acc_x saturates at 16'h7FFF.
REQ-025 btn and move both pending in IDLE -> btn packet first, move packet next.
REQ-026 No traffic for KEEPALIVE_CYCLES -> poll packet {F0,56'h0}; resp_src=2.
REQ-027 rst_n low during WAIT -> all outputs at reset values; stray spi_rx_valid after reset produces no resp_valid.
